// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI word receiver:
// FSM state encoding and default parameter values.
package spi_rx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    localparam int WORD_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int MSB_FIRST_DEF  = 1;

endpackage

// File: rtl/spi_word_receiver_if.sv
// Valid/ready word stream carrying received SPI words
// from the receiver to its consumer.
interface spi_word_receiver_if #(
    parameter int W = 16
) (
    input logic clk
);

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        input  clk,
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  clk,
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, extra pointer bit
// separates full from empty. A push while full only lands with a pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW])
                && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/spi_word_receiver.sv
// SPI mode-0 slave receiver: synchronises the SPI pins into clk,
// assembles WORD_WIDTH-bit words and queues them in an output FIFO.
module spi_word_receiver
    import spi_rx_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MSB_FIRST  = MSB_FIRST_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [WORD_WIDTH-1:0] sh_next;
    logic                  push_q, push_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;

    logic bit_evt, cs_fall, cs_rise;
    logic fifo_full, fifo_empty, pop;

    // Idle values match a deselected, quiet bus so reset never fakes an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign bit_evt = sclk_sync_q && !sclk_prev_q && !cs_sync_q;
    assign cs_fall = !cs_sync_q && cs_prev_q;
    assign cs_rise = cs_sync_q && !cs_prev_q;

    always_comb begin
        if (MSB_FIRST != 0) begin
            sh_next = {shreg_q[WORD_WIDTH-2:0], mosi_sync_q};
        end else begin
            sh_next = {mosi_sync_q, shreg_q[WORD_WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        ovf_d   = push_q && fifo_full && !pop;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ferr_d  = (cnt_q != '0);
                end else if (bit_evt) begin
                    shreg_d = sh_next;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d  = '0;
                        push_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    // shreg_q holds the finished word for the push cycle; the next
    // bit cannot arrive sooner than several clk cycles later
    assign pop = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_q),
        .push_data (shreg_q),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign overflow    = ovf_q;
    assign frame_error = ferr_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Scoreboard bench for spi_word_receiver: a 16-bit MSB-first
// instance and an 8-bit LSB-first instance.
module tb_spi_word_receiver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic sclk, smosi, scs;
    logic s8clk, s8mosi, s8cs;
    logic ovf, ferr, ovf8, ferr8;

    spi_word_receiver_if #(.W(16)) rx  (.clk(clk));
    spi_word_receiver_if #(.W(8))  rx8 (.clk(clk));

    spi_word_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .spi_clk     (sclk),
        .spi_mosi    (smosi),
        .spi_cs_n    (scs),
        .out_data    (rx.data),
        .out_valid   (rx.valid),
        .out_ready   (rx.ready),
        .overflow    (ovf),
        .frame_error (ferr)
    );

    spi_word_receiver #(
        .WORD_WIDTH (8),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (0)
    ) dut8 (
        .clk         (clk),
        .reset       (reset),
        .spi_clk     (s8clk),
        .spi_mosi    (s8mosi),
        .spi_cs_n    (s8cs),
        .out_data    (rx8.data),
        .out_valid   (rx8.valid),
        .out_ready   (rx8.ready),
        .overflow    (ovf8),
        .frame_error (ferr8)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int ovf_cnt = 0, ferr_cnt = 0, ovf8_cnt = 0, ferr8_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Handshake inputs only change at posedge+1, so negedge sees the
    // same valid/ready pair the next rising edge will act on.
    always @(negedge clk) begin
        if (reset) begin
            if (rx.valid && rx.ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_data16 unexpected: got %0h want none",
                             rx.data);
                end else begin
                    check("out_data16", 32'(rx.data), 32'(exp_q.pop_front()));
                end
            end
            if (rx8.valid && rx8.ready) begin
                if (exp8_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_data8 unexpected: got %0h want none",
                             rx8.data);
                end else begin
                    check("out_data8", 32'(rx8.data), 32'(exp8_q.pop_front()));
                end
            end
            if (ovf)   ovf_cnt++;
            if (ferr)  ferr_cnt++;
            if (ovf8)  ovf8_cnt++;
            if (ferr8) ferr8_cnt++;
        end
    end

    task automatic bit16(input logic b);
        smosi = b;
        #40 sclk = 1'b1;
        #40 sclk = 1'b0;
    endtask

    task automatic send16(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) bit16(w[i]);
    endtask

    task automatic start16();
        scs = 1'b0;
        #40;
    endtask

    task automatic end16();
        #40 scs = 1'b1;
        #80;
    endtask

    task automatic bit8(input logic b);
        s8mosi = b;
        #40 s8clk = 1'b1;
        #40 s8clk = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 rx.ready = r;
    endtask

    task automatic drain16(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 0);
        cyc(3);
        check({name, "_valid_low"}, 32'(rx.valid), 0);
    endtask

    int base;
    logic hit;

    initial begin
        reset  = 1'b0;
        sclk   = 1'b0;
        smosi  = 1'b0;
        scs    = 1'b1;
        s8clk  = 1'b0;
        s8mosi = 1'b0;
        s8cs   = 1'b1;
        rx.ready  = 1'b1;
        rx8.ready = 1'b1;
        #22;
        check("rst_valid", 32'(rx.valid), 0);
        check("rst_data", 32'(rx.data), 0);
        check("rst_overflow", 32'(ovf), 0);
        check("rst_frame_error", 32'(ferr), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(5);

        // 48-bit MSB-first stream, three back-to-back words in one frame
        exp_q.push_back(16'hdead);
        exp_q.push_back(16'hbeef);
        exp_q.push_back(16'h0000);
        start16();
        send16(16'hdead, 16);
        send16(16'hbeef, 16);
        send16(16'h0000, 16);
        end16();
        drain16("stream3");
        check("stream3_overflow", 32'(ovf_cnt), 0);
        check("stream3_frame_error", 32'(ferr_cnt), 0);

        // LSB-first byte: first wire bit lands in bit 0
        exp8_q.push_back(8'h80);
        s8cs = 1'b0;
        #40;
        for (int i = 7; i >= 0; i--) bit8(i == 0);
        #40 s8cs = 1'b1;
        for (int i = 0; i < 200 && exp8_q.size() != 0; i++) @(posedge clk);
        #1;
        check("lsb_first_drain", 32'(exp8_q.size()), 0);
        check("lsb_first_frame_error", 32'(ferr8_cnt), 0);

        // Six words into a stalled depth-4 FIFO
        set_ready(1'b0);
        base = ovf_cnt;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        start16();
        send16(16'h1111, 16);
        send16(16'h2222, 16);
        send16(16'h3333, 16);
        send16(16'h4444, 16);
        send16(16'h5555, 16);
        send16(16'h6666, 16);
        end16();
        cyc(20);
        check("full_overflow_pulses", 32'(ovf_cnt - base), 2);
        check("full_valid", 32'(rx.valid), 1);
        check("full_head", 32'(rx.data), 32'h1111);
        set_ready(1'b1);
        drain16("full_drain");

        // Partial word aborted by cs_n, then a clean frame
        base = ferr_cnt;
        start16();
        send16(16'hffff, 5);
        end16();
        cyc(5);
        check("partial_frame_error", 32'(ferr_cnt - base), 1);
        exp_q.push_back(16'h1234);
        start16();
        send16(16'h1234, 16);
        end16();
        drain16("after_partial");
        check("after_partial_ferr", 32'(ferr_cnt - base), 1);

        // Reset in mid-frame drops the partial word
        start16();
        send16(16'habcd, 10);
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(rx.valid), 0);
        check("midrst_data", 32'(rx.data), 0);
        check("midrst_overflow", 32'(ovf), 0);
        check("midrst_frame_error", 32'(ferr), 0);
        scs = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(4);
        exp_q.push_back(16'h5555);
        start16();
        send16(16'h5555, 16);
        end16();
        drain16("after_reset");

        // Full FIFO, pop and push on the same edge
        set_ready(1'b0);
        base = ovf_cnt;
        exp_q.push_back(16'ha001);
        exp_q.push_back(16'ha002);
        exp_q.push_back(16'ha003);
        exp_q.push_back(16'ha004);
        start16();
        send16(16'ha001, 16);
        send16(16'ha002, 16);
        send16(16'ha003, 16);
        send16(16'ha004, 16);
        end16();
        cyc(10);
        exp_q.push_back(16'ha005);
        hit = 1'b0;
        fork
            begin
                start16();
                send16(16'ha005, 16);
                end16();
            end
            begin
                for (int k = 0; k < 400 && !hit; k++) begin
                    @(posedge clk);
                    #1;
                    if (dut.push_q) begin
                        hit = 1'b1;
                        rx.ready = 1'b1;
                        @(posedge clk);
                        #1 rx.ready = 1'b0;
                    end
                end
            end
        join
        check("same_edge_seen", 32'(hit), 1);
        cyc(10);
        check("same_edge_overflow", 32'(ovf_cnt - base), 0);
        check("same_edge_valid", 32'(rx.valid), 1);
        check("same_edge_head", 32'(rx.data), 32'ha002);
        set_ready(1'b1);
        drain16("same_edge_drain");

        check("final_q16", 32'(exp_q.size()), 0);
        check("final_q8", 32'(exp8_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_word_receiver.md
SPI_WORD_RECEIVER -- requirements
Module: spi_word_receiver

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: bits per received word; legal range 2..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = first SPI bit lands in the MSB; 0 = first bit lands in the LSB.
REQ-004 SHALL have port clk, input, 1: the single system clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port spi_clk, input, 1: SPI clock, asynchronous to clk, mode 0 (sample on rising edge).
REQ-007 SHALL have port spi_mosi, input, 1: SPI data, asynchronous to clk.
REQ-008 SHALL have port spi_cs_n, input, 1: active-low chip select framing words, asynchronous to clk.
REQ-009 SHALL have port out_data, output, WORD_WIDTH: word at FIFO head.
REQ-010 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_data when out_valid=1.
REQ-012 SHALL have port overflow, output, 1: one-cycle pulse when a completed word is dropped.
REQ-013 SHALL have port frame_error, output, 1: one-cycle pulse when spi_cs_n rises with a partial word.

Function
REQ-014 SHALL pass spi_clk, spi_mosi and spi_cs_n each through a 2-flop synchroniser into clk; mosi and cs delayed to stay aligned with the clk path.
REQ-015 SHALL detect an SPI bit as a synchronised spi_clk 0->1 transition while synchronised spi_cs_n=0; clk frequency is at least 4x spi_clk.
REQ-016 SHALL implement FSM states IDLE and SHIFT: IDLE->SHIFT on synchronised cs_n falling; SHIFT->IDLE on synchronised cs_n rising.
REQ-017 SHALL, on each bit in SHIFT, shift the synchronised mosi into the shift register per MSB_FIRST and increment a bit counter of width clog2(WORD_WIDTH+1).
REQ-018 SHALL, on the bit that brings the count to WORD_WIDTH, present the assembled word for a FIFO push on the next clk edge and clear the count to 0 while remaining in SHIFT, so consecutive words need no cs_n toggle.
REQ-019 SHALL assert out_valid on the clk cycle after the push edge; there is no bypass path, even into an empty FIFO.
REQ-020 SHALL pop the FIFO head on any clk edge where out_valid=1 and out_ready=1; out_data is don't-care while out_valid=0.
REQ-021 SHALL accept a push when the FIFO is full only if a pop occurs on the same edge; otherwise it SHALL drop the word, leave the FIFO unchanged and pulse overflow for one cycle.
REQ-022 SHALL, on a cs_n rise in SHIFT with a nonzero bit count, discard the partial word, clear the count and pulse frame_error for one cycle; with a zero count, no pulse.
REQ-023 SHALL ignore spi_clk edges while in IDLE.
REQ-024 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH, using one extra bit to distinguish full from empty.

Reset
REQ-025 SHALL, while reset=0, force state IDLE, bit count 0, shift register 0, FIFO empty, out_valid=0, out_data=0, overflow=0, frame_error=0, and synchroniser flops to idle values (spi_clk 0, cs_n 1, mosi 0).
REQ-026 SHALL discard any in-flight word on reset mid-frame, and after reset release SHALL NOT start a word until a fresh synchronised cs_n falling edge.

Structure
REQ-027 SHALL place the FSM state encoding and the default parameter values in a shared package, spi_rx_pkg.
REQ-028 SHALL implement the FIFO as a separate sub-module, sync_fifo (parameters WIDTH and DEPTH), reusable by the hub75 pixel path.

Verification
REQ-029 SHALL cover: defaults, cs_n low, 48 bits 0xdeadbeef0000 MSB-first, out_ready=1 -> out_data 0xdead, 0xbeef, 0x0000 in order, no overflow or frame_error.
REQ-030 SHALL cover: MSB_FIRST=0, WORD_WIDTH=8, byte stream 0x01 -> out_data 0x80.
REQ-031 SHALL cover: out_ready=0, FIFO_DEPTH=4, six 16-bit words -> four words held, overflow pulses exactly twice, then drain yields the first four in order.
REQ-032 SHALL cover: cs_n raised after 5 bits of a 16-bit word -> one frame_error pulse; the next full frame 0x1234 -> out_data 0x1234.
REQ-033 SHALL cover: reset asserted after 10 bits of 0xabcd -> all outputs 0 immediately; after release, full frame 0x5555 -> only 0x5555 emitted.
REQ-034 SHALL cover: FIFO full with out_ready=1 and a word completing on the same edge -> push accepted, no overflow, occupancy remains FIFO_DEPTH.
